power_integrate_dump: RTL and testbench
=======================================

// Module: power_integrate_dump
// PURPOSE
//  Integrate-and-dump stage directly downstream of the 18-bit complex |x|^2 unit.
//  Sums a programmable number of valid 36-bit power samples into one window total,
//  then presents that total for one cycle with a valid strobe.
//  Optionally also tracks the peak sample and its index within the window.
//  Feeds the detection/threshold logic.
// PARAMETERS
//  LEN_W  10  width of the window-length input; max window = 2^LEN_W-1 samples
// PORTS
//  i_clk       in   1          system clock; all logic on rising edge
//  i_rst       in   1          asynchronous, active-high reset
//  i_start     in   1          pulse: open a window (ignored unless IDLE)
//  i_cont      in   1          continuous mode: auto-reopen window after each dump
//  i_len       in   LEN_W      samples per window; latched at window open
//  i_vld       in   1          i_p valid this cycle
//  i_p         in   36         power sample, treated as UNSIGNED
//  o_sum       out  36+LEN_W   window total, valid with o_vld
//  o_peak      out  36         largest sample of window (POWER_PEAK_EN)
//  o_peak_idx  out  LEN_W      0-based index of o_peak in window (POWER_PEAK_EN)
//  o_vld       out  1          one-cycle strobe: outputs hold a finished window
//  o_busy      out  1          high while a window is open (state ACC)
// BEHAVIOUR
//  - Reset: state IDLE; o_sum, o_peak, o_peak_idx, o_vld, o_busy, accumulator, count = 0.
//  - States: IDLE, ACC.
//  - IDLE -> ACC: i_start=1 and i_len!=0. Latch len=i_len; clear count.
//    i_start with i_len==0: ignored, stay IDLE.
//  - i_start and i_vld in the same IDLE cycle: that sample is sample 0 of the window.
//  - ACC: each i_vld=1 adds i_p; count+1. i_vld=0 cycles are stalls (no change).
//  - Accumulator width 36+LEN_W; no overflow possible for any len <= 2^LEN_W-1.
//  - Last sample (i_vld=1 and count==len-1): next cycle o_vld=1 and o_sum = full total,
//    including the last sample. Latency: last sample -> o_vld = 1 cycle.
//  - o_sum, o_peak, o_peak_idx hold their value until the next dump; o_vld is high 1 cycle.
//  - After last sample, i_cont=0: go to IDLE.
//  - After last sample, i_cont=1: stay ACC; re-latch len from i_len the same cycle;
//    the next valid sample is sample 0 of the new window. No lost samples, no gap.
//    If re-latched i_len==0: go to IDLE.
//  - i_start while ACC: ignored. Changing i_len mid-window has no effect.
//  - o_busy = (state==ACC), registered.
//  - Reset mid-window: window discarded; no o_vld is produced.
// CONFIGURATION
//  POWER_PEAK_EN defined:
//    - Track the maximum i_p per window; update only on strictly greater.
//    - Ties keep the earliest index. Sample 0 always initialises the peak.
//    - o_peak/o_peak_idx update together with o_sum at the dump.
//  POWER_PEAK_EN undefined:
//    - No peak logic synthesised.
//    - o_peak=0 and o_peak_idx=0 constantly.
// TESTING
//  1. len=4, start, i_p=10,20,30,40 back-to-back
//     -> 1 cycle after the 40: o_vld=1, o_sum=100, o_peak=40, o_peak_idx=3.
//  2. len=3, samples 5,_,_,7,_,9 (stalls between)
//     -> o_sum=21, exactly one o_vld, o_busy low the cycle after the dump.
//  3. i_cont=1, len=2, stream 1,2,3,4,5,6 continuous
//     -> o_vld three times with o_sum 3, 7, 11; no gap cycles.
//  4. len=3, i_p=36'hF_FFFF_FFFF x3 -> o_sum=3*(2^36-1), no wrap.
//     Ties -> o_peak_idx=0.
//  5. i_start with i_len=0 -> stays IDLE, o_busy=0, no o_vld.
//     i_start during ACC -> ignored.
//  6. len=4, reset after 2 samples -> all outputs 0, no o_vld.
//     New start len=1, i_p=9 -> o_sum=9.

Source files
------------

// File: rtl/power_integrate_dump.sv
// Integrate-and-dump of unsigned 36-bit power samples over a programmable window.
// Define POWER_PEAK_EN to also report each window's peak sample and its index.
module power_integrate_dump #(
  parameter int LEN_W = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_cont,
  input  logic [LEN_W-1:0]    i_len,
  input  logic                i_vld,
  input  logic [35:0]         i_p,
  output logic [36+LEN_W-1:0] o_sum,
  output logic [35:0]         o_peak,
  output logic [LEN_W-1:0]    o_peak_idx,
  output logic                o_vld,
  output logic                o_busy
);

  localparam int SW = 36 + LEN_W;

  typedef enum logic {IDLE, ACC} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     acc_q, acc_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic              vld_q, vld_d;

  logic              win_open, last;
  logic [LEN_W-1:0]  eff_len, eff_cnt;
  logic [SW-1:0]     eff_acc, new_acc;

  // In IDLE a start with a valid sample counts that sample as sample 0, so the
  // window bookkeeping is taken from the inputs rather than the registers.
  always_comb begin
    win_open = (state_q == ACC) || (i_start && (i_len != '0));
    eff_len  = (state_q == ACC) ? len_q : i_len;
    eff_cnt  = (state_q == ACC) ? cnt_q : '0;
    eff_acc  = (state_q == ACC) ? acc_q : '0;
    new_acc  = eff_acc + SW'(i_p);
    last     = (eff_cnt == (eff_len - LEN_W'(1)));
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    vld_d   = 1'b0;
    if (win_open) begin
      state_d = ACC;
      len_d   = eff_len;
      cnt_d   = eff_cnt;
      acc_d   = eff_acc;
      if (i_vld) begin
        if (last) begin
          sum_d   = new_acc;
          vld_d   = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
          len_d   = i_len;
          state_d = (i_cont && (i_len != '0)) ? ACC : IDLE;
        end else begin
          acc_d = new_acc;
          cnt_d = eff_cnt + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      vld_q   <= vld_d;
    end
  end

  assign o_sum  = sum_q;
  assign o_vld  = vld_q;
  assign o_busy = (state_q == ACC);

`ifdef POWER_PEAK_EN
  logic [35:0]      pk_q, pk_d, opk_q, opk_d, new_pk;
  logic [LEN_W-1:0] pidx_q, pidx_d, opidx_q, opidx_d, new_pidx;

  // Strictly-greater update keeps the earliest index on ties.
  always_comb begin
    new_pk   = pk_q;
    new_pidx = pidx_q;
    if ((eff_cnt == '0) || (i_p > pk_q)) begin
      new_pk   = i_p;
      new_pidx = eff_cnt;
    end
    pk_d    = pk_q;
    pidx_d  = pidx_q;
    opk_d   = opk_q;
    opidx_d = opidx_q;
    if (win_open && i_vld) begin
      pk_d   = new_pk;
      pidx_d = new_pidx;
      if (last) begin
        opk_d   = new_pk;
        opidx_d = new_pidx;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pk_q    <= '0;
      pidx_q  <= '0;
      opk_q   <= '0;
      opidx_q <= '0;
    end else begin
      pk_q    <= pk_d;
      pidx_q  <= pidx_d;
      opk_q   <= opk_d;
      opidx_q <= opidx_d;
    end
  end

  assign o_peak     = opk_q;
  assign o_peak_idx = opidx_q;
`else
  assign o_peak     = '0;
  assign o_peak_idx = '0;
`endif

endmodule

// File: tb/tb_power_integrate_dump.sv
// Directed bench for power_integrate_dump; expected dumps are queued as the
// last sample of each window is driven and compared when o_vld appears.
module tb_power_integrate_dump;

  localparam int LEN_W = 10;
  localparam int SW    = 36 + LEN_W;
`ifdef POWER_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start, i_cont, i_vld;
  logic [LEN_W-1:0] i_len;
  logic [35:0]      i_p;
  logic [SW-1:0]    o_sum;
  logic [35:0]      o_peak;
  logic [LEN_W-1:0] o_peak_idx;
  logic             o_vld, o_busy;

  typedef struct {
    logic [SW-1:0]    sum;
    logic [35:0]      peak;
    logic [LEN_W-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_vld  = 0;

  power_integrate_dump #(.LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cont(i_cont),
    .i_len(i_len), .i_vld(i_vld), .i_p(i_p), .o_sum(o_sum), .o_peak(o_peak),
    .o_peak_idx(o_peak_idx), .o_vld(o_vld), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [SW-1:0] sum, input logic [35:0] pk, input int idx);
    exp_t e;
    e.sum  = sum;
    e.peak = PK ? pk : 36'd0;
    e.idx  = PK ? LEN_W'(idx) : '0;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic s, input logic c, input logic v,
                      input logic [35:0] p, input int len);
    i_start = s;
    i_cont  = c;
    i_vld   = v;
    i_p     = p;
    i_len   = LEN_W'(len);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 36'd0, 0);
  endtask

  // Scoreboard side: every o_vld must match the oldest queued window.
  always @(negedge i_clk) begin
    if (!i_rst && (o_vld === 1'b1)) begin
      n_vld++;
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", 64'(o_vld), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", 64'(o_sum), 64'(e.sum));
        chk("peak", 64'(o_peak), 64'(e.peak));
        chk("peak_idx", 64'(o_peak_idx), 64'(e.idx));
      end
    end
  end

  initial begin
    int v0;
    i_rst = 1'b1;
    i_start = 1'b0; i_cont = 1'b0; i_vld = 1'b0; i_p = '0; i_len = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_sum", 64'(o_sum), 64'd0);
    chk("rst_vld", 64'(o_vld), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_peak", 64'(o_peak), 64'd0);
    chk("rst_peak_idx", 64'(o_peak_idx), 64'd0);
    i_rst = 1'b0;
    idle(1);

    // 1: back-to-back window of 4
    v0 = n_vld;
    step(1, 0, 1, 36'd10, 4);
    chk("t1_busy", 64'(o_busy), 64'd1);
    step(0, 0, 1, 36'd20, 4);
    step(0, 0, 1, 36'd30, 4);
    push(100, 36'd40, 3);
    step(0, 0, 1, 36'd40, 4);
    chk("t1_vld_latency", 64'(o_vld), 64'd1);
    chk("t1_busy_after", 64'(o_busy), 64'd0);
    idle(3);
    chk("t1_nvld", 64'(n_vld - v0), 64'd1);
    chk("t1_sum_hold", 64'(o_sum), 64'd100);

    // 2: stalls inside a window of 3
    v0 = n_vld;
    step(1, 0, 1, 36'd5, 3);
    step(0, 0, 0, 36'd99, 3);
    step(0, 0, 0, 36'd99, 3);
    step(0, 0, 1, 36'd7, 3);
    step(0, 0, 0, 36'd99, 3);
    chk("t2_busy_mid", 64'(o_busy), 64'd1);
    push(21, 36'd9, 2);
    step(0, 0, 1, 36'd9, 3);
    chk("t2_busy_dump", 64'(o_busy), 64'd0);
    idle(3);
    chk("t2_nvld", 64'(n_vld - v0), 64'd1);

    // 3: continuous mode, windows of 2 with no gap
    v0 = n_vld;
    step(1, 1, 1, 36'd1, 2);
    push(3, 36'd2, 1);
    step(0, 1, 1, 36'd2, 2);
    chk("t3_vld0", 64'(o_vld), 64'd1);
    chk("t3_busy0", 64'(o_busy), 64'd1);
    step(0, 1, 1, 36'd3, 2);
    push(7, 36'd4, 1);
    step(0, 1, 1, 36'd4, 2);
    chk("t3_busy1", 64'(o_busy), 64'd1);
    step(0, 1, 1, 36'd5, 2);
    push(11, 36'd6, 1);
    step(0, 0, 1, 36'd6, 2);
    chk("t3_busy_end", 64'(o_busy), 64'd0);
    idle(3);
    chk("t3_nvld", 64'(n_vld - v0), 64'd3);

    // 4: full-scale samples, all equal
    v0 = n_vld;
    step(1, 0, 1, 36'hF_FFFF_FFFF, 3);
    step(0, 0, 1, 36'hF_FFFF_FFFF, 3);
    push(46'h2F_FFFF_FFFD, 36'hF_FFFF_FFFF, 0);
    step(0, 0, 1, 36'hF_FFFF_FFFF, 3);
    idle(2);
    chk("t4_nvld", 64'(n_vld - v0), 64'd1);

    // 5: zero-length start ignored; start / len change during ACC ignored
    v0 = n_vld;
    step(1, 0, 1, 36'd50, 0);
    chk("t5_len0_busy", 64'(o_busy), 64'd0);
    idle(2);
    chk("t5_len0_nvld", 64'(n_vld - v0), 64'd0);
    step(1, 0, 1, 36'd3, 2);
    step(1, 0, 0, 36'd0, 7);
    chk("t5_busy_mid", 64'(o_busy), 64'd1);
    push(7, 36'd4, 1);
    step(1, 0, 1, 36'd4, 7);
    chk("t5_busy_after", 64'(o_busy), 64'd0);
    idle(3);
    chk("t5_nvld", 64'(n_vld - v0), 64'd1);
    chk("t5_busy_idle", 64'(o_busy), 64'd0);

    // 6: reset mid-window, then a one-sample window
    v0 = n_vld;
    step(1, 0, 1, 36'd1, 4);
    step(0, 0, 1, 36'd2, 4);
    i_rst = 1'b1;
    #2;
    chk("t6_rst_sum", 64'(o_sum), 64'd0);
    chk("t6_rst_busy", 64'(o_busy), 64'd0);
    chk("t6_rst_vld", 64'(o_vld), 64'd0);
    chk("t6_rst_peak", 64'(o_peak), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(2);
    chk("t6_rst_nvld", 64'(n_vld - v0), 64'd0);
    push(9, 36'd9, 0);
    step(1, 0, 1, 36'd9, 1);
    chk("t6_len1_vld", 64'(o_vld), 64'd1);
    idle(3);
    chk("t6_nvld", 64'(n_vld - v0), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
